// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-port register file.
// master = datapath side (drives strobes/addresses/data), slave = register file.
`timescale 1ns/1ps
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, rd_valid, clr_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, rd_valid, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised NUM_RD-read / NUM_WR-write register file with
// registered read ports, optional hardwired-zero entry 0 and a clear sequencer
// that zeroes one entry per cycle.
// Optional feature: define REGFILE_BYPASS_EN for write-first same-cycle
// read/write ordering; left undefined the file is read-first.
`timescale 1ns/1ps
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic { IDLE, SWEEP } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                clr_busy_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   rd_word [NUM_RD];
  logic [DATA_W-1:0]   rd_data_q [NUM_RD];
  logic [DATA_W-1:0]   rd_data_d [NUM_RD];
  logic [NUM_RD-1:0]   rd_valid_q;
  logic [NUM_RD-1:0]   rd_valid_d;
  logic                sweep;

  assign sweep = (state_q == SWEEP);

  // Per-port read value: array contents, optional same-cycle bypass, zero entry override.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_word[p] = mem_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan so the highest-index matching write port wins, like the array update.
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] == bus.rd_addr[p*ADDR_W +: ADDR_W]))
          rd_word[p] = bus.wr_data[w*DATA_W +: DATA_W];
      end
`endif
      if ((ZERO_REG != 0) && (bus.rd_addr[p*ADDR_W +: ADDR_W] == '0))
        rd_word[p] = '0;
    end
  end

  // Next read-port state: load on strobe (zeroed while sweeping), otherwise hold.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_d[p]  = rd_data_q[p];
      rd_valid_d[p] = 1'b0;
      if (bus.rd_en[p]) begin
        rd_data_d[p]  = sweep ? '0 : rd_word[p];
        rd_valid_d[p] = !sweep;
      end
    end
  end

  // Next array contents: sweep clears one entry, otherwise apply writes in port order.
  always_comb begin
    mem_d = mem_q;
    if (sweep) begin
      mem_d[cnt_q] = '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] &&
            !((ZERO_REG != 0) && (bus.wr_addr[w*ADDR_W +: ADDR_W] == '0)))
          mem_d[bus.wr_addr[w*ADDR_W +: ADDR_W]] = bus.wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  // Array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Clear sequencer: IDLE -> SWEEP on clr_req, one entry per cycle, back after the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.clr_req) begin
        state_q    <= SWEEP;
        cnt_q      <= '0;
        clr_busy_q <= 1'b1;
      end
    end else begin
      if (cnt_q == LAST_IDX) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        clr_busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_out
    assign bus.rd_data[p*DATA_W +: DATA_W] = rd_data_q[p];
  end
  assign bus.rd_valid = rd_valid_q;
  assign bus.clr_busy = clr_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default 32x32, 2R/2W, ZERO_REG=1)
// plus a ZERO_REG=0 instance for the ordinary-entry-0 case.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  regfile_mp_if bus ();
  regfile_mp_if bus_nz ();

  regfile_mp dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_mp #(.ZERO_REG(0)) dut_nz (.clk(clk), .rst_n(rst_n), .bus(bus_nz));

  // Behavioural reference: plain array, sweep position (-1 when idle), expected outputs.
  logic [31:0] mdl_mem [32];
  int          sweep_pos;
  logic [31:0] exp_data [2];
  logic [1:0]  exp_valid;
  logic        exp_busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.rd_en = '0; bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0;
    bus_nz.rd_en = '0; bus_nz.rd_addr = '0; bus_nz.wr_en = '0; bus_nz.wr_addr = '0;
    bus_nz.wr_data = '0; bus_nz.clr_req = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [4:0] a);
    bus.rd_en[p] = en;
    bus.rd_addr[p*5 +: 5] = a;
  endtask

  task automatic set_wr(input int w, input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en[w] = en;
    bus.wr_addr[w*5 +: 5] = a;
    bus.wr_data[w*32 +: 32] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    sweep_pos = -1;
    exp_data[0] = '0; exp_data[1] = '0;
    exp_valid = '0;
    exp_busy = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = mdl_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < 2; w++)
      if (bus.wr_en[w] && bus.wr_addr[w*5 +: 5] == a) v = bus.wr_data[w*32 +: 32];
`endif
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  // Advance one clock: derive expected outputs from the model, then apply the edge.
  task automatic tick();
    for (int p = 0; p < 2; p++) begin
      if (bus.rd_en[p]) begin
        if (sweep_pos >= 0) begin
          exp_data[p] = '0; exp_valid[p] = 1'b0;
        end else begin
          exp_data[p] = model_read(bus.rd_addr[p*5 +: 5]); exp_valid[p] = 1'b1;
        end
      end else begin
        exp_valid[p] = 1'b0;
      end
    end
    if (sweep_pos >= 0) begin
      mdl_mem[sweep_pos] = '0;
      sweep_pos = (sweep_pos == 31) ? -1 : sweep_pos + 1;
    end else begin
      for (int w = 0; w < 2; w++)
        if (bus.wr_en[w] && bus.wr_addr[w*5 +: 5] != 5'd0)
          mdl_mem[bus.wr_addr[w*5 +: 5]] = bus.wr_data[w*32 +: 32];
      if (bus.clr_req) sweep_pos = 0;
    end
    exp_busy = (sweep_pos >= 0);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      set_wr(0, 1'b1, 5'(i), $urandom() | 32'h1);
      set_wr(1, 1'b1, 5'(i + 16), $urandom() | 32'h1);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h required 0", bus.rd_data); end
    n_checks++;
    if (bus.rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rd_valid: got %b required 00", bus.rd_valid); end
    n_checks++;
    if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b required 0", bus.clr_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    set_wr(0, 1'b1, 5'd3, 32'hCAFE0003);
    set_wr(1, 1'b1, 5'd20, 32'hCAFE0014);
    tick();
    idle_inputs();
    set_rd(0, 1'b1, 5'd3); set_rd(1, 1'b1, 5'd20);
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (bus.rd_data !== 64'h0) begin n_fail++; $display("FAIL midreset_rd_data: got %h required 0", bus.rd_data); end
    n_checks++;
    if (bus.rd_valid !== 2'b00) begin n_fail++; $display("FAIL midreset_rd_valid: got %b required 00", bus.rd_valid); end
    n_checks++;
    if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_clr_busy: got %b required 0", bus.clr_busy); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      set_rd(0, 1'b1, 5'(i)); set_rd(1, 1'b1, 5'(i + 16));
      tick();
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (bus.rd_data[p*32 +: 32] !== 32'h0 || bus.rd_valid[p] !== 1'b1) begin
          n_fail++;
          $display("FAIL postreset_read port%0d addr%0d: got %h/%b required 0/1", p, i + p*16,
                   bus.rd_data[p*32 +: 32], bus.rd_valid[p]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_basic_rw();
    idle_inputs();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    idle_inputs();
    set_rd(0, 1'b1, 5'd5); set_rd(1, 1'b1, 5'd5);
    tick();
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (bus.rd_data[p*32 +: 32] !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL basic_rw_data port%0d: got %h required deadbeef", p, bus.rd_data[p*32 +: 32]);
      end
    end
    n_checks++;
    if (bus.rd_valid !== 2'b11) begin n_fail++; $display("FAIL basic_rw_valid: got %b required 11", bus.rd_valid); end
    idle_inputs();
    tick();
    n_checks++;
    if (bus.rd_valid !== 2'b00 || bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_rw_hold: got %h/%b required deadbeef/00", bus.rd_data[31:0], bus.rd_valid);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    set_wr(0, 1'b1, 5'd0, 32'h12345678);
    bus_nz.wr_en[0] = 1'b1; bus_nz.wr_addr[4:0] = 5'd0; bus_nz.wr_data[31:0] = 32'h12345678;
    tick();
    idle_inputs();
    set_rd(0, 1'b1, 5'd0);
    bus_nz.rd_en[0] = 1'b1; bus_nz.rd_addr[4:0] = 5'd0;
    tick();
    n_checks++;
    if (bus.rd_data[31:0] !== 32'h0 || bus.rd_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL zero_reg: got %h/%b required 0/1", bus.rd_data[31:0], bus.rd_valid[0]);
    end
    n_checks++;
    if (bus_nz.rd_data[31:0] !== 32'h12345678) begin
      n_fail++; $display("FAIL zero_reg_off: got %h required 12345678", bus_nz.rd_data[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_write_conflict();
    idle_inputs();
    set_wr(0, 1'b1, 5'd7, 32'h1111);
    set_wr(1, 1'b1, 5'd7, 32'h2222);
    tick();
    idle_inputs();
    set_rd(1, 1'b1, 5'd7);
    tick();
    n_checks++;
    if (bus.rd_data[63:32] !== 32'h2222) begin
      n_fail++; $display("FAIL write_conflict: got %h required 2222", bus.rd_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] first;
`ifdef REGFILE_BYPASS_EN
    first = 32'hB;
`else
    first = 32'hA;
`endif
    idle_inputs();
    set_wr(0, 1'b1, 5'd9, 32'hA);
    tick();
    idle_inputs();
    set_wr(1, 1'b1, 5'd9, 32'hB);
    set_rd(0, 1'b1, 5'd9);
    tick();
    n_checks++;
    if (bus.rd_data[31:0] !== first) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h required %h", bus.rd_data[31:0], first);
    end
    idle_inputs();
    set_rd(0, 1'b1, 5'd9);
    tick();
    n_checks++;
    if (bus.rd_data[31:0] !== 32'hB) begin
      n_fail++; $display("FAIL bypass_next_read: got %h required b", bus.rd_data[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cycles;
    int guard;
    logic was_busy;
    fill_all();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    busy_cycles = 0;
    guard = 0;
    while (bus.clr_busy === 1'b1 && guard < 100) begin
      busy_cycles++;
      guard++;
      was_busy = bus.clr_busy;
      set_wr(0, 1'b1, 5'($urandom_range(1, 31)), $urandom() | 32'h1);
      set_wr(1, 1'b1, 5'($urandom_range(1, 31)), $urandom() | 32'h1);
      set_rd(0, 1'b1, 5'($urandom_range(1, 31)));
      set_rd(1, 1'b1, 5'($urandom_range(1, 31)));
      bus.clr_req = (guard == 5);
      tick();
      if (was_busy) begin
        n_checks++;
        if (bus.rd_valid !== 2'b00 || bus.rd_data !== 64'h0) begin
          n_fail++; $display("FAIL sweep_read_forced: got %h/%b required 0/00", bus.rd_data, bus.rd_valid);
        end
      end
    end
    idle_inputs();
    n_checks++;
    if (guard >= 100) begin n_fail++; $display("FAIL clear_timeout: got busy after %0d cycles required release", guard); end
    n_checks++;
    if (busy_cycles != 32) begin n_fail++; $display("FAIL clear_busy_len: got %0d required 32", busy_cycles); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL clear_no_restart: got %b required 0", bus.clr_busy); end
    end
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      set_rd(0, 1'b1, 5'(i)); set_rd(1, 1'b1, 5'(i + 16));
      tick();
      n_checks++;
      if (bus.rd_data !== 64'h0 || bus.rd_valid !== 2'b11) begin
        n_fail++; $display("FAIL clear_contents addr%0d/%0d: got %h/%b required 0/11", i, i + 16, bus.rd_data, bus.rd_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_reset();
    fill_all();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    n_checks++;
    if (bus.clr_busy !== 1'b1) begin n_fail++; $display("FAIL clrrst_busy_start: got %b required 1", bus.clr_busy); end
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL clrrst_busy: got %b required 0", bus.clr_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      set_rd(0, 1'b1, 5'(i)); set_rd(1, 1'b1, 5'(i + 16));
      tick();
      n_checks++;
      if (bus.rd_data !== 64'h0 || bus.rd_valid !== 2'b11 || bus.clr_busy !== 1'b0) begin
        n_fail++; $display("FAIL clrrst_contents addr%0d/%0d: got %h/%b/%b required 0/11/0", i, i + 16,
                           bus.rd_data, bus.rd_valid, bus.clr_busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      for (int p = 0; p < 2; p++) set_rd(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      for (int w = 0; w < 2; w++) begin
        // Narrow address range so same-address write/read collisions are frequent.
        set_wr(w, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
               $urandom());
      end
      bus.clr_req = ($urandom_range(0, 63) == 0);
      tick();
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (bus.rd_data[p*32 +: 32] !== exp_data[p] || bus.rd_valid[p] !== exp_valid[p]) begin
          n_fail++; $display("FAIL random_read it%0d port%0d: got %h/%b required %h/%b", it, p,
                             bus.rd_data[p*32 +: 32], bus.rd_valid[p], exp_data[p], exp_valid[p]);
        end
      end
      n_checks++;
      if (bus.clr_busy !== exp_busy) begin
        n_fail++; $display("FAIL random_busy it%0d: got %b required %b", it, bus.clr_busy, exp_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic_rw();
    test_zero_reg();
    test_write_conflict();
    test_bypass();
    test_reset_mid_op();
    test_clear();
    test_clear_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
